// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants, FSM encoding and lane helpers for the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } lsu_state_t;

  // Width is func3[1:0] for every legal encoding, so alignment only looks at those bits.
  function automatic logic access_legal(input logic       is_store,
                                        input logic [2:0] func3,
                                        input logic [1:0] off);
    logic ok_f3;
    logic ok_al;
    if (is_store) begin
      ok_f3 = (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W);
    end else begin
      ok_f3 = (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W) ||
              (func3 == F3_BU) || (func3 == F3_HU);
    end
    case (func3[1:0])
      2'b00:   ok_al = 1'b1;
      2'b01:   ok_al = ~off[0];
      2'b10:   ok_al = (off == 2'b00);
      default: ok_al = 1'b0;
    endcase
    return ok_f3 && ok_al;
  endfunction

  function automatic logic [3:0] lane_enables(input logic [2:0] func3,
                                              input logic [1:0] off);
    logic [3:0] be;
    case (func3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0]  func3,
                                              input logic [31:0] rs2);
    logic [31:0] wd;
    case (func3[1:0])
      2'b00:   wd = {4{rs2[7:0]}};
      2'b01:   wd = {2{rs2[15:0]}};
      default: wd = rs2;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects the addressed byte/half of a read word and extends it
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  func3,
  output logic [31:0] result
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    case (off)
      2'b00:   sel_b = rdata[7:0];
      2'b01:   sel_b = rdata[15:8];
      2'b10:   sel_b = rdata[23:16];
      default: sel_b = rdata[31:24];
    endcase
    sel_h = off[1] ? rdata[31:16] : rdata[15:0];

    case (func3)
      F3_B:    result = {{24{sel_b[7]}}, sel_b};
      F3_H:    result = {{16{sel_h[15]}}, sel_h};
      F3_W:    result = rdata;
      F3_BU:   result = {24'h000000, sel_b};
      F3_HU:   result = {16'h0000, sel_h};
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - address generation, legality check and req/ack data-memory access FSM
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  func3,
  input  logic [31:0] rs1_val,
  input  logic [31:0] imm,
  input  logic [31:0] rs2_val,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        exc_misalign,
  output logic        exc_timeout,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);
  import lsu_pkg::*;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_t       state;
  lsu_state_t       state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [31:0]      addr;
  logic             legal;
  logic             accept;
  logic             fin_ack;
  logic             fin_to;
  logic             mis_n;
  logic [1:0]       r_off;
  logic [2:0]       r_func3;
  logic [31:0]      align_data;

  load_align u_align (
    .rdata  (dmem_rdata),
    .off    (r_off),
    .func3  (r_func3),
    .result (align_data)
  );

  assign busy     = (state != ST_IDLE);
  assign dmem_req = (state == ST_REQ);

  always_comb begin
    addr    = rs1_val + imm;
    legal   = access_legal(is_store, func3, addr[1:0]);
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    mis_n   = 1'b0;
    fin_ack = 1'b0;
    fin_to  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (legal) begin
            accept  = 1'b1;
            cnt_n   = '0;
            state_n = ST_REQ;
          end else begin
            mis_n = 1'b1;
          end
        end
      end
      ST_REQ: begin
        // An ack on the final allowed cycle still completes the access.
        if (dmem_ack) begin
          fin_ack = 1'b1;
          state_n = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          fin_to  = 1'b1;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      done         <= 1'b0;
      exc_misalign <= 1'b0;
      exc_timeout  <= 1'b0;
      load_data    <= 32'h0000_0000;
      dmem_we      <= 1'b0;
      dmem_addr    <= 32'h0000_0000;
      dmem_be      <= 4'h0;
      dmem_wdata   <= 32'h0000_0000;
      r_off        <= 2'b00;
      r_func3      <= 3'b000;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      done         <= fin_ack;
      exc_misalign <= mis_n;
      exc_timeout  <= fin_to;
      if (accept) begin
        dmem_addr  <= {addr[31:2], 2'b00};
        r_off      <= addr[1:0];
        r_func3    <= func3;
        dmem_we    <= is_store;
        dmem_be    <= lane_enables(func3, addr[1:0]);
        dmem_wdata <= is_store ? store_lanes(func3, rs2_val) : 32'h0000_0000;
      end
      if (fin_ack && !dmem_we) begin
        load_data <= align_data;
      end
    end
  end

endmodule
